uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate in bit/s.
REQ-003 clk  input  1  system clock, 50 MHz nominal, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset; one clock, reset asynchronous and active-low.
REQ-005 tx_en  input  1  request to send tx_data; sampled every rising edge.
REQ-006 tx_data  input  8  byte to transmit; captured on the accepting edge only.
REQ-007 txd  output  1  serial line, idle high.
REQ-008 tx_busy  output  1  high while a frame is in progress.
REQ-009 tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 Bit period BPS_CNT SHALL be CLK_FREQ/BAUD clocks (integer division); 5208 at defaults; bit counter width 16 bits minimum.
REQ-011 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-012 PARITY is present only per REQ-026; without it, DATA goes directly to STOP.
REQ-013 In IDLE, txd=1 and tx_busy=0.
REQ-014 tx_en=1 in IDLE SHALL latch tx_data into a shift register and enter START on that edge.
REQ-015 txd SHALL go low and tx_busy high in the first cycle after the accepting edge; latency is exactly 1 clock.
REQ-016 START drives txd=0 for BPS_CNT clocks, then enters DATA.
REQ-017 DATA sends 8 bits LSB first, BPS_CNT clocks each; a 3-bit index counts 0..7, then DATA exits.
REQ-018 STOP drives txd=1 for BPS_CNT clocks, then enters IDLE.
REQ-019 tx_done SHALL be 1 for exactly the first IDLE cycle after STOP; tx_busy is 0 in that cycle.
REQ-020 tx_en while tx_busy=1 SHALL be ignored; the frame in flight and the latched byte are unaffected by tx_data changes.
REQ-021 tx_en=1 in the tx_done cycle SHALL be accepted; back-to-back frames then have a 1-clock idle-high gap.
REQ-022 The bit-period counter SHALL reset to 0 on every state or bit change; there is no cumulative drift within a frame.
REQ-023 txd SHALL be driven from a register; it is glitch-free.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, txd=1, tx_busy=0, tx_done=0, counters and shift register cleared.
REQ-025 Reset mid-frame SHALL abort the frame, force txd high immediately, and send no partial byte after release; the first tx_en after release starts a fresh frame.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: after DATA, PARITY drives the even-parity bit (XOR of the 8 latched data bits) for BPS_CNT clocks, then STOP; frame is 11 bits.
REQ-027 UART_TX_PARITY_EN undefined: no PARITY state or logic; frame is 10 bits (8N1).

Verification
REQ-028 Reset then idle 1000 clocks -> txd=1, tx_busy=0, tx_done never pulses.
REQ-029 tx_en 1 cycle with tx_data=0x55 -> txd sequence 0,1,0,1,0,1,0,1,0,1, each bit 5208 clocks; tx_done pulses at clock 52081 after accept (no parity).
REQ-030 UART_TX_PARITY_EN with tx_data=0x07 -> parity bit 1, 11-bit frame, tx_done at clock 57289; with tx_data=0x03 -> parity bit 0.
REQ-031 tx_data=0xA3, then tx_en=1 with tx_data=0xFF mid-frame -> line carries 0xA3 only, and no second frame starts.
REQ-032 tx_en held high continuously with tx_data=0x00 -> repeated frames separated by exactly 1 idle-high clock, with one tx_done per frame.
REQ-033 rst_n low for 3 clocks during DATA bit 4 of 0x0F -> txd=1 within the same cycle, tx_busy=0, and a later tx_en with 0x81 produces a correct full frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle between a byte source and the UART transmitter.
interface uart_tx_if;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_en,
    output tx_data,
    input  txd,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_en,
    input  tx_data,
    output txd,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, 1 stop bit. Defining UART_TX_PARITY_EN
// inserts an even-parity bit before the stop bit (8E1, 11-bit frame).
module uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  bus
);

  localparam int BPS_CNT = CLK_FREQ / BAUD;
  localparam int CNT_W   = ($clog2(BPS_CNT) > 16) ? $clog2(BPS_CNT) : 16;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

`ifdef UART_TX_PARITY_EN
  function automatic logic f_even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_txd;
  logic             r_busy;
  logic             r_done;
`ifdef UART_TX_PARITY_EN
  logic             r_par;
`endif

  logic [2:0]       w_state_nxt;
  logic             w_bit_end;
  logic             w_txd_nxt;

  assign w_bit_end = (r_cnt == CNT_W'(BPS_CNT - 1));

  // Next-state selection; every bit period ends on the same counter terminal value.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.tx_en) w_state_nxt = START;
        else           w_state_nxt = IDLE;
      end
      START: begin
        if (w_bit_end) w_state_nxt = DATA;
        else           w_state_nxt = START;
      end
      DATA: begin
`ifdef UART_TX_PARITY_EN
        if (w_bit_end && (r_idx == 3'd7)) w_state_nxt = PARITY;
        else                              w_state_nxt = DATA;
`else
        if (w_bit_end && (r_idx == 3'd7)) w_state_nxt = STOP;
        else                              w_state_nxt = DATA;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) w_state_nxt = STOP;
        else           w_state_nxt = PARITY;
      end
`endif
      STOP: begin
        if (w_bit_end) w_state_nxt = IDLE;
        else           w_state_nxt = STOP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level for the next cycle, so txd comes straight from a flop.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      IDLE:  w_txd_nxt = 1'b1;
      START: w_txd_nxt = 1'b0;
      DATA: begin
        if ((r_state == DATA) && w_bit_end) w_txd_nxt = r_shift[1];
        else                                w_txd_nxt = r_shift[0];
      end
`ifdef UART_TX_PARITY_EN
      PARITY: w_txd_nxt = r_par;
`endif
      STOP:    w_txd_nxt = 1'b1;
      default: w_txd_nxt = 1'b1;
    endcase
  end

  // State, bit timing, data path and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (r_state == STOP) && w_bit_end;

      if ((r_state == IDLE) || w_bit_end) r_cnt <= '0;
      else                                r_cnt <= r_cnt + CNT_W'(1);

      if (r_state != DATA)  r_idx <= 3'd0;
      else if (w_bit_end)   r_idx <= r_idx + 3'd1;
      else                  r_idx <= r_idx;

      if ((r_state == IDLE) && bus.tx_en) begin
        r_shift <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
        r_par   <= f_even_parity(bus.tx_data);
`endif
      end else if ((r_state == DATA) && w_bit_end) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end else begin
        r_shift <= r_shift;
      end
    end
  end

  assign bus.txd     = r_txd;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed scoreboard bench for uart_tx; scaled bit period keeps runs short.
module tb_uart_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int BPS      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS    = 11;
`else
  localparam int NBITS    = 10;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  uart_tx_if bus ();

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    int errs;
    errs = 0;
    repeat (n) begin
      @(negedge clk);
      if ({bus.tx_done, bus.tx_busy, bus.txd} !== 3'b001) errs++;
    end
    chk(tag, errs, 0);
  endtask

  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    bus.tx_en   = 1'b1;
    bus.tx_data = d;
    sb_q.push_back(d);
  endtask

  // Called right after the accepting edge is armed; checks every cycle of the frame.
  task automatic check_frame(input bit keep_en, input bit poke);
    logic [7:0]       d;
    logic [NBITS-1:0] f;
    int errs;
    int k;
    d = sb_q.pop_front();
`ifdef UART_TX_PARITY_EN
    f = {1'b1, ^d, d, 1'b0};
`else
    f = {1'b1, d, 1'b0};
`endif
    for (int b = 0; b < NBITS; b++) begin
      errs = 0;
      for (int c = 0; c < BPS; c++) begin
        @(negedge clk);
        if ({bus.tx_done, bus.tx_busy, bus.txd} !== {1'b0, 1'b1, f[b]}) errs++;
        k = b * BPS + c + 1;
        if ((k == 1) && !keep_en) bus.tx_en = 1'b0;
        if (poke && (k == 3 * BPS + 2)) begin
          bus.tx_en   = 1'b1;
          bus.tx_data = 8'hFF;
        end else if (poke && (k == 3 * BPS + 3)) begin
          bus.tx_en   = 1'b0;
        end
      end
      chk($sformatf("frame%02h_bit%0d_badcycles", d, b), errs, 0);
    end
    @(negedge clk);
    chk($sformatf("frame%02h_done_busy_txd", d), {29'd0, bus.tx_done, bus.tx_busy, bus.txd}, 32'd5);
  endtask

  initial begin
    bus.tx_en   = 1'b0;
    bus.tx_data = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset_done_busy_txd", {29'd0, bus.tx_done, bus.tx_busy, bus.txd}, 32'd1);
    rst_n = 1'b1;
    idle_check("idle_1000", 1000);

    start_frame(8'h55);
    check_frame(1'b0, 1'b0);
    idle_check("after_55", 2 * BPS);

    start_frame(8'h07);
    check_frame(1'b0, 1'b0);
    start_frame(8'h03);
    check_frame(1'b0, 1'b0);

    start_frame(8'hA3);
    check_frame(1'b0, 1'b1);
    idle_check("no_second_frame_after_A3", 3 * BPS * NBITS);

    start_frame(8'h00);
    bus.tx_data = 8'h00;
    sb_q.push_back(8'h00);
    sb_q.push_back(8'h00);
    check_frame(1'b1, 1'b0);
    check_frame(1'b1, 1'b0);
    check_frame(1'b0, 1'b0);
    idle_check("after_backtoback", 2 * BPS);

    start_frame(8'($urandom_range(0, 255)));
    check_frame(1'b0, 1'b0);

    // Reset in the middle of data bit 4 of 0x0F (that bit is 0 on the line).
    @(negedge clk);
    bus.tx_en   = 1'b1;
    bus.tx_data = 8'h0F;
    @(negedge clk);
    bus.tx_en   = 1'b0;
    repeat (5 * BPS + BPS / 2 - 1) @(negedge clk);
    chk("bit4_of_0F_before_reset", {31'd0, bus.txd}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_done_busy_txd", {29'd0, bus.tx_done, bus.tx_busy, bus.txd}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("idle_after_reset", 3 * BPS * NBITS);

    start_frame(8'h81);
    check_frame(1'b0, 1'b0);
    idle_check("idle_end", 2 * BPS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
